ps2_rx_frame: RTL
=================

// Module: ps2_rx_frame
// PURPOSE
//  Receives PS/2 device-to-host frames from the debounced PS/2 clock and data lines.
//  Sits directly downstream of the debounce stages, one stage per line.
//  Detects falling edges of ps2_clk_db and shifts an 11-bit frame: start, 8 data bits LSB-first, odd parity, stop.
//  Delivers each byte with a 1-cycle valid strobe to the scancode decoder.
//  Flags parity, framing and timeout errors.
// PARAMETERS
//  TIMEOUT_CYCLES  10000  max clk cycles between PS/2 falling edges inside a frame (200us @ 50MHz)
//  CNT_W           14     timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock; all logic is on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  ps2_clk_db   in   1  debounced PS/2 clock, already synchronous to clk
//  ps2_data_db  in   1  debounced PS/2 data, already synchronous to clk
//  rx_en        in   1  receive enable; low forces IDLE
//  data_out     out  8  last correctly received byte
//  data_valid   out  1  1-cycle pulse; data_out is new this cycle
//  parity_err   out  1  1-cycle pulse; odd-parity check failed
//  frame_err    out  1  1-cycle pulse; stop bit sampled as 0
//  timeout_err  out  1  1-cycle pulse; frame abandoned due to inter-edge timeout
//  busy         out  1  high while state != IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  Reset values:
//   - all outputs 0, state = IDLE, bit counter 0
//   - clk_prev = 1 (PS/2 idle-high), so there is no spurious edge after reset
//  Edge detect:
//   - fall = clk_prev & ~ps2_clk_db
//   - ps2_data_db is sampled in the same cycle as fall
//  States: IDLE -> DATA -> PARITY -> STOP -> IDLE
//   - IDLE:
//     - fall with data=0 -> DATA, bit counter = 0
//     - fall with data=1 is a glitch: stay in IDLE, no flag
//   - DATA:
//     - each fall shifts data into shreg[7] and shifts right
//     - after the 8th bit (counter 7) -> PARITY
//   - PARITY: on fall, latch par_ok = ^{shreg, data}; par_ok==1 means odd parity is correct -> STOP
//   - STOP: on fall -> IDLE and, in the next cycle, exactly one of:
//     - stop=1 & par_ok: data_out <= shreg, data_valid = 1
//     - stop=1 & !par_ok: parity_err = 1, data_out is held
//     - stop=0: frame_err = 1, regardless of parity
//  Latency: data_valid is asserted 1 clk after the cycle that samples the stop-bit falling edge.
//  Timeout:
//   - counter clears on every fall and in IDLE; it increments saturating in DATA, PARITY and STOP
//   - reaching TIMEOUT_CYCLES-1 -> timeout_err pulse next cycle, state -> IDLE, partial byte discarded
//  Enable:
//   - rx_en=0 holds IDLE and suppresses all strobes
//   - deasserting rx_en mid-frame aborts silently, with no error pulse
//  Simultaneous events: a fall in the same cycle the timeout counter hits its limit is honoured as the fall (counter clears, no timeout).
//  Reset mid-frame aborts immediately; no strobe is emitted.
//  Strobes are mutually exclusive and never exceed 1 cycle.
// STRUCTURE
//  ps2_pkg (shared):
//   - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t
//   - localparam PS2_DATA_BITS = 8
//   - localparam PS2_FRAME_BITS = 11
//  Sub-module ps2_edge_detect (clk, rst_n, in, fall, rise): reset-to-1 history register; reused by the host-to-device transmitter.
//  Remaining logic (FSM, shift register, timeout counter) lives in this module.
// TESTING
//  1. Frame 0x1C: bits 0, 0,0,1,1,1,0,0,0, par 0, stop 1 -> data_out=0x1C, data_valid high exactly 1 clk, no errors.
//  2. Frame 0xF0 with parity bit 0 (correct value is 1) -> parity_err 1 clk, data_valid 0, data_out unchanged.
//  3. Frame 0xAA, parity 1, stop bit 0 -> frame_err 1 clk only.
//  4. Stall after 5 data bits for TIMEOUT_CYCLES clk -> timeout_err 1 clk, busy 0.
//     Then frame 0x55 (parity 1) -> data_valid, data_out=0x55.
//  5. Falling edge with data=1 while IDLE -> busy stays 0, no strobe.
//     Then a valid 0x1C frame is received normally.
//  6. rst_n low mid-frame (after 3 bits), and separately rx_en low mid-frame -> IDLE, all outputs 0, no strobes.
//     Next full frame 0xF0 (parity 1) -> data_out=0xF0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the receive and transmit paths.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_rx_state_t;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   // PS/2 uses odd parity: the XOR over data plus parity bit must be 1.
   function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                              input logic                     par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_edge_detect.sv
// Edge detector for a line that idles high; history resets to 1 so no edge follows reset.
module ps2_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic fall,
   output logic rise
);

   logic prev_r;

   // one-cycle history of the monitored line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r <= 1'b1;
      end else begin
         prev_r <= in;
      end
   end

   assign fall = prev_r & ~in;
   assign rise = ~prev_r & in;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB-first, odd parity, stop.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CNT_W          = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_db,
   input  logic       ps2_data_db,
   input  logic       rx_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       timeout_err,
   output logic       busy
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = {CNT_W{1'b1}};

   ps2_rx_state_t             state_r, state_s;
   logic [2:0]                bit_r, bit_s;
   logic [PS2_DATA_BITS-1:0]  shreg_r, shreg_s;
   logic                      par_ok_r, par_ok_s;
   logic [CNT_W-1:0]          tmo_r, tmo_s;
   logic [7:0]                data_out_r, data_out_s;
   logic                      valid_r, valid_s;
   logic                      perr_r, perr_s;
   logic                      ferr_r, ferr_s;
   logic                      terr_r, terr_s;
   logic                      busy_r;
   logic                      fall_s;
   logic                      edge_rise_unused_s;

   ps2_edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (ps2_clk_db),
      .fall  (fall_s),
      .rise  (edge_rise_unused_s)
   );

   // state, datapath and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         bit_r      <= 3'd0;
         shreg_r    <= 8'h00;
         par_ok_r   <= 1'b0;
         tmo_r      <= {CNT_W{1'b0}};
         data_out_r <= 8'h00;
         valid_r    <= 1'b0;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         terr_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         bit_r      <= bit_s;
         shreg_r    <= shreg_s;
         par_ok_r   <= par_ok_s;
         tmo_r      <= tmo_s;
         data_out_r <= data_out_s;
         valid_r    <= valid_s;
         perr_r     <= perr_s;
         ferr_r     <= ferr_s;
         terr_r     <= terr_s;
         busy_r     <= (state_s != IDLE);
      end
   end

   // next-state, shift, timeout and strobe decode; a fall always wins over the timeout
   always_comb begin
      state_s    = state_r;
      bit_s      = bit_r;
      shreg_s    = shreg_r;
      par_ok_s   = par_ok_r;
      tmo_s      = tmo_r;
      data_out_s = data_out_r;
      valid_s    = 1'b0;
      perr_s     = 1'b0;
      ferr_s     = 1'b0;
      terr_s     = 1'b0;

      if (!rx_en) begin
         state_s = IDLE;
         bit_s   = 3'd0;
         tmo_s   = {CNT_W{1'b0}};
      end else if (state_r == IDLE) begin
         tmo_s = {CNT_W{1'b0}};
         if (fall_s && !ps2_data_db) begin
            state_s = DATA;
            bit_s   = 3'd0;
         end else begin
            state_s = IDLE;
         end
      end else if (fall_s) begin
         tmo_s = {CNT_W{1'b0}};
         case (state_r)
            DATA: begin
               shreg_s = {ps2_data_db, shreg_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = PARITY;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end
            PARITY: begin
               par_ok_s = ps2_odd_parity_ok(shreg_r, ps2_data_db);
               state_s  = STOP;
            end
            STOP: begin
               state_s = IDLE;
               bit_s   = 3'd0;
               if (!ps2_data_db) begin
                  ferr_s = 1'b1;
               end else if (par_ok_r) begin
                  valid_s    = 1'b1;
                  data_out_s = shreg_r;
               end else begin
                  perr_s = 1'b1;
               end
            end
            default: begin
               state_s = IDLE;
               bit_s   = 3'd0;
            end
         endcase
      end else if (tmo_r == TMO_LAST) begin
         terr_s  = 1'b1;
         state_s = IDLE;
         bit_s   = 3'd0;
         tmo_s   = {CNT_W{1'b0}};
      end else if (tmo_r != TMO_MAX) begin
         tmo_s = tmo_r + CNT_W'(1);
      end else begin
         tmo_s = tmo_r;
      end
   end

   assign data_out    = data_out_r;
   assign data_valid  = valid_r;
   assign parity_err  = perr_r;
   assign frame_err   = ferr_r;
   assign timeout_err = terr_r;
   assign busy        = busy_r;

endmodule
